// File: rtl/biriscv_mul_issue_ctrl_if.sv
// Signal bundle between the multiplier issue controller and its environment
// (issue stage, multiplier unit, register-file write port).
interface biriscv_mul_issue_ctrl_if;
  logic        issue_valid_i;
  logic        issue_accept_o;
  logic [31:0] issue_opcode_i;
  logic [31:0] issue_pc_i;
  logic [4:0]  issue_rd_idx_i;
  logic [4:0]  issue_ra_idx_i;
  logic [4:0]  issue_rb_idx_i;
  logic [31:0] issue_ra_operand_i;
  logic [31:0] issue_rb_operand_i;

  logic        opcode_valid_o;
  logic [31:0] opcode_opcode_o;
  logic [31:0] opcode_pc_o;
  logic        opcode_invalid_o;
  logic [4:0]  opcode_rd_idx_o;
  logic [4:0]  opcode_ra_idx_o;
  logic [4:0]  opcode_rb_idx_o;
  logic [31:0] opcode_ra_operand_o;
  logic [31:0] opcode_rb_operand_o;

  logic        writeback_valid_i;
  logic [31:0] writeback_value_i;
  logic [4:0]  writeback_rd_idx_i;

  logic [4:0]  check_ra_idx_i;
  logic [4:0]  check_rb_idx_i;
  logic        hazard_o;
  logic        busy_o;

  logic        rf_wr_valid_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic        rf_wr_ready_i;

  logic        error_o;

  // The controller is the initiator towards the multiplier unit.
  modport master (
    input  issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i, issue_ra_idx_i,
           issue_rb_idx_i, issue_ra_operand_i, issue_rb_operand_i,
           writeback_valid_i, writeback_value_i, writeback_rd_idx_i,
           check_ra_idx_i, check_rb_idx_i, rf_wr_ready_i,
    output issue_accept_o, opcode_valid_o, opcode_opcode_o, opcode_pc_o, opcode_invalid_o,
           opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o, opcode_ra_operand_o,
           opcode_rb_operand_o, hazard_o, busy_o, rf_wr_valid_o, rf_wr_idx_o,
           rf_wr_value_o, error_o
  );

  modport slave (
    output issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i, issue_ra_idx_i,
           issue_rb_idx_i, issue_ra_operand_i, issue_rb_operand_i,
           writeback_valid_i, writeback_value_i, writeback_rd_idx_i,
           check_ra_idx_i, check_rb_idx_i, rf_wr_ready_i,
    input  issue_accept_o, opcode_valid_o, opcode_opcode_o, opcode_pc_o, opcode_invalid_o,
           opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o, opcode_ra_operand_o,
           opcode_rb_operand_o, hazard_o, busy_o, rf_wr_valid_o, rf_wr_idx_o,
           rf_wr_value_o, error_o
  );
endinterface

// File: rtl/biriscv_mul_issue_ctrl.sv
// Issue-side controller for the multi-cycle multiplier: one instruction in flight,
// pending-rd hazard tracking, writeback capture and register-file retirement.
module biriscv_mul_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic                           clk_i,
  input logic                           rst_ni,
  biriscv_mul_issue_ctrl_if.master      bus
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRetire} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  logic        latch;

  logic [31:0] opcode_q, pc_q, ra_op_q, rb_op_q;
  logic [4:0]  rd_q, ra_idx_q, rb_idx_q;
  logic [7:0]  cnt_inc;
  logic        busy;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = 1'b0;
    latch    = 1'b0;
    unique case (state_q)
      StIdle: begin
        error_d = bus.writeback_valid_i;
        if (bus.issue_valid_i) begin
          latch   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        error_d = bus.writeback_valid_i;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        // A writeback arriving in the timeout cycle still counts as on time.
        if (bus.writeback_valid_i) begin
          if (bus.writeback_rd_idx_i != rd_q) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else if (rd_q == 5'd0) begin
            state_d = StIdle;
          end else begin
            result_d = bus.writeback_value_i;
            state_d  = StRetire;
          end
        end else if (cnt_inc == TimeoutCnt) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StRetire: begin
        error_d = bus.writeback_valid_i;
        if (bus.rf_wr_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode_q <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      ra_idx_q <= '0;
      rb_idx_q <= '0;
      ra_op_q  <= '0;
      rb_op_q  <= '0;
    end else if (latch) begin
      opcode_q <= bus.issue_opcode_i;
      pc_q     <= bus.issue_pc_i;
      rd_q     <= bus.issue_rd_idx_i;
      ra_idx_q <= bus.issue_ra_idx_i;
      rb_idx_q <= bus.issue_rb_idx_i;
      ra_op_q  <= bus.issue_ra_operand_i;
      rb_op_q  <= bus.issue_rb_operand_i;
    end
  end

  assign busy = (state_q != StIdle);

  assign bus.issue_accept_o      = ~busy;
  assign bus.busy_o              = busy;
  assign bus.opcode_valid_o      = (state_q == StIssue);
  assign bus.opcode_opcode_o     = opcode_q;
  assign bus.opcode_pc_o         = pc_q;
  assign bus.opcode_invalid_o    = 1'b0;
  assign bus.opcode_rd_idx_o     = rd_q;
  assign bus.opcode_ra_idx_o     = ra_idx_q;
  assign bus.opcode_rb_idx_o     = rb_idx_q;
  assign bus.opcode_ra_operand_o = ra_op_q;
  assign bus.opcode_rb_operand_o = rb_op_q;

  // No forwarding path, so the pending rd stays hazardous until retirement completes.
  assign bus.hazard_o = busy && (rd_q != 5'd0) &&
                        ((bus.check_ra_idx_i == rd_q) || (bus.check_rb_idx_i == rd_q));

  assign bus.rf_wr_valid_o = (state_q == StRetire);
  assign bus.rf_wr_idx_o   = rd_q;
  assign bus.rf_wr_value_o = result_q;
  assign bus.error_o       = error_q;

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Self-checking bench: table-driven and random transactions checked against a
// per-transaction timeline model, plus reset and spurious-writeback sequences.
module tb_biriscv_mul_issue_ctrl;
  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  biriscv_mul_issue_ctrl_if bus ();

  biriscv_mul_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  ra_idx;
    logic [4:0]  rb_idx;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] opcode;
    logic [31:0] pc;
    int          lat;        // unit latency from opcode_valid to writeback; >T = never
    logic [4:0]  wb_rd;
    int          rdy_dly;    // cycles rf_wr_ready stays low in retirement
    int          spur;       // cycle of an extra spurious writeback, -1 for none
    bit          exp_retire;
    bit          exp_err;
    int          exp_end;    // cycle index at which the controller is idle again
    logic [31:0] exp_value;
  } txn_t;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i      = 1'b0;
    bus.issue_opcode_i     = '0;
    bus.issue_pc_i         = '0;
    bus.issue_rd_idx_i     = '0;
    bus.issue_ra_idx_i     = '0;
    bus.issue_rb_idx_i     = '0;
    bus.issue_ra_operand_i = '0;
    bus.issue_rb_operand_i = '0;
    bus.writeback_valid_i  = 1'b0;
    bus.writeback_value_i  = '0;
    bus.writeback_rd_idx_i = '0;
    bus.check_ra_idx_i     = '0;
    bus.check_rb_idx_i     = '0;
    bus.rf_wr_ready_i      = 1'b0;
  endtask

  // Timeline from the rules: issue at 0, opcode at 1, WAIT from 2 for at most T cycles.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_retire = 1'b0;
    r.exp_err    = 1'b0;
    r.exp_value  = t.ra * t.rb;
    if (t.lat > int'(T)) begin
      r.exp_err = 1'b1;
      r.exp_end = 2 + int'(T);
    end else if (t.wb_rd != t.rd) begin
      r.exp_err = 1'b1;
      r.exp_end = 2 + t.lat;
    end else if (t.rd == 5'd0) begin
      r.exp_end = 2 + t.lat;
    end else begin
      r.exp_retire = 1'b1;
      r.exp_end    = 3 + t.lat + t.rdy_dly;
    end
    return r;
  endfunction

  function automatic txn_t mk(input logic [4:0] rd, input logic [31:0] ra, input logic [31:0] rb,
                              input int lat, input logic [4:0] wb_rd, input int rdy,
                              input int spur, input bit ret, input bit err, input int e_end,
                              input logic [31:0] val);
    txn_t t;
    t.rd = rd; t.ra_idx = 5'd1; t.rb_idx = 5'd2; t.ra = ra; t.rb = rb;
    t.opcode = 32'h02B5_0533; t.pc = 32'h8000_0100;
    t.lat = lat; t.wb_rd = wb_rd; t.rdy_dly = rdy; t.spur = spur;
    t.exp_retire = ret; t.exp_err = err; t.exp_end = e_end; t.exp_value = val;
    return t;
  endfunction

  task automatic run_txn(input txn_t t);
    bit busy_e, rfv_e, err_e, haz_e;
    for (int k = 0; k <= t.exp_end; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.issue_valid_i      = 1'b1;
        bus.issue_opcode_i     = t.opcode;
        bus.issue_pc_i         = t.pc;
        bus.issue_rd_idx_i     = t.rd;
        bus.issue_ra_idx_i     = t.ra_idx;
        bus.issue_rb_idx_i     = t.rb_idx;
        bus.issue_ra_operand_i = t.ra;
        bus.issue_rb_operand_i = t.rb;
      end else begin
        // Offers while busy must be ignored, so present junk.
        bus.issue_valid_i      = (k < t.exp_end) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.issue_opcode_i     = $urandom;
        bus.issue_pc_i         = $urandom;
        bus.issue_rd_idx_i     = 5'($urandom_range(0, 31));
        bus.issue_ra_idx_i     = 5'($urandom_range(0, 31));
        bus.issue_rb_idx_i     = 5'($urandom_range(0, 31));
        bus.issue_ra_operand_i = $urandom;
        bus.issue_rb_operand_i = $urandom;
      end
      bus.writeback_valid_i  = 1'b0;
      bus.writeback_rd_idx_i = t.wb_rd;
      bus.writeback_value_i  = $urandom;
      if (k == 1 + t.lat && t.lat <= int'(T)) begin
        bus.writeback_valid_i = 1'b1;
        bus.writeback_value_i = t.ra * t.rb;
      end
      if (k == t.spur) begin
        bus.writeback_valid_i  = 1'b1;
        bus.writeback_rd_idx_i = 5'($urandom_range(0, 31));
      end
      if (t.exp_retire && k >= 2 + t.lat) bus.rf_wr_ready_i = (k >= 2 + t.lat + t.rdy_dly);
      else bus.rf_wr_ready_i = 1'($urandom_range(0, 1));
      bus.check_ra_idx_i = ($urandom_range(0, 1) == 1) ? t.rd : 5'($urandom_range(0, 31));
      bus.check_rb_idx_i = 5'($urandom_range(0, 31));
      #1;
      busy_e = (k >= 1) && (k < t.exp_end);
      rfv_e  = t.exp_retire && (k >= 2 + t.lat) && (k < t.exp_end);
      err_e  = (k == t.exp_end && t.exp_err) || (t.spur >= 0 && k == t.spur + 1);
      haz_e  = busy_e && (t.rd != 5'd0) &&
               (bus.check_ra_idx_i == t.rd || bus.check_rb_idx_i == t.rd);
      chk("busy", k, 32'(bus.busy_o), 32'(busy_e));
      chk("issue_accept", k, 32'(bus.issue_accept_o), 32'(!busy_e));
      chk("opcode_valid", k, 32'(bus.opcode_valid_o), 32'(k == 1));
      chk("rf_wr_valid", k, 32'(bus.rf_wr_valid_o), 32'(rfv_e));
      chk("error", k, 32'(bus.error_o), 32'(err_e));
      chk("hazard", k, 32'(bus.hazard_o), 32'(haz_e));
      if (busy_e) chk("pending_rd", k, 32'(bus.opcode_rd_idx_o), 32'(t.rd));
      if (k == 1) begin
        chk("opcode_opcode", k, bus.opcode_opcode_o, t.opcode);
        chk("opcode_pc", k, bus.opcode_pc_o, t.pc);
        chk("opcode_invalid", k, 32'(bus.opcode_invalid_o), 32'd0);
        chk("opcode_ra_idx", k, 32'(bus.opcode_ra_idx_o), 32'(t.ra_idx));
        chk("opcode_rb_idx", k, 32'(bus.opcode_rb_idx_o), 32'(t.rb_idx));
        chk("opcode_ra_op", k, bus.opcode_ra_operand_o, t.ra);
        chk("opcode_rb_op", k, bus.opcode_rb_operand_o, t.rb);
      end
      if (rfv_e) begin
        chk("rf_wr_idx", k, 32'(bus.rf_wr_idx_o), 32'(t.rd));
        chk("rf_wr_value", k, bus.rf_wr_value_o, t.exp_value);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_accept"}, 0, 32'(bus.issue_accept_o), 32'd1);
    chk({tag, "_busy"}, 0, 32'(bus.busy_o), 32'd0);
    chk({tag, "_hazard"}, 0, 32'(bus.hazard_o), 32'd0);
    chk({tag, "_opvalid"}, 0, 32'(bus.opcode_valid_o), 32'd0);
    chk({tag, "_rfvalid"}, 0, 32'(bus.rf_wr_valid_o), 32'd0);
    chk({tag, "_error"}, 0, 32'(bus.error_o), 32'd0);
    chk({tag, "_rd"}, 0, 32'(bus.opcode_rd_idx_o), 32'd0);
    chk({tag, "_raop"}, 0, bus.opcode_ra_operand_o, 32'd0);
    chk({tag, "_rfvalue"}, 0, bus.rf_wr_value_o, 32'd0);
  endtask

  txn_t vec[7];

  initial begin
    idle_inputs();
    vec[0] = mk(5'd5, 32'h0001_0003, 32'h0002_0005, 5, 5'd5, 0, -1, 1, 0, 8, 32'h000B_000F);
    vec[1] = mk(5'd5, 32'h0001_0003, 32'h0002_0005, 5, 5'd5, 4, 9, 1, 0, 12, 32'h000B_000F);
    vec[2] = mk(5'd0, 32'h0000_0007, 32'h0000_0009, 5, 5'd0, 0, -1, 0, 0, 7, 32'h0);
    vec[3] = mk(5'd3, 32'h1234_5678, 32'h0000_0002, T + 5, 5'd3, 0, -1, 0, 1, 10, 32'h0);
    vec[4] = mk(5'd9, 32'h0000_0002, 32'h0000_0003, 3, 5'd7, 0, -1, 0, 1, 5, 32'h0);
    vec[5] = mk(5'd12, 32'h0000_0003, 32'h0000_0004, 8, 5'd12, 1, -1, 1, 0, 12, 32'h0000_000C);
    vec[6] = mk(5'd31, 32'hFFFF_FFFF, 32'h0000_0002, 1, 5'd31, 2, 1, 1, 0, 6, 32'hFFFF_FFFE);

    #1;
    chk_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    for (int i = 0; i < 25; i++) begin
      txn_t t;
      t.rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      t.ra_idx  = 5'($urandom_range(0, 31));
      t.rb_idx  = 5'($urandom_range(0, 31));
      t.ra      = $urandom;
      t.rb      = $urandom;
      t.opcode  = $urandom;
      t.pc      = $urandom;
      t.lat     = $urandom_range(1, T + 2);
      t.wb_rd   = ($urandom_range(0, 4) == 0) ? (t.rd ^ 5'($urandom_range(1, 31))) : t.rd;
      t.rdy_dly = $urandom_range(0, 5);
      t.spur    = -1;
      run_txn(model(t));
    end

    // Spurious writeback while idle: flagged one cycle later, state untouched.
    @(negedge clk);
    bus.writeback_valid_i  = 1'b1;
    bus.writeback_rd_idx_i = 5'd4;
    bus.writeback_value_i  = 32'hDEAD_BEEF;
    #1;
    chk("idle_wb_accept", 0, 32'(bus.issue_accept_o), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("idle_wb_error", 1, 32'(bus.error_o), 32'd1);
    chk("idle_wb_busy", 1, 32'(bus.busy_o), 32'd0);
    chk("idle_wb_rfvalid", 1, 32'(bus.rf_wr_valid_o), 32'd0);
    @(negedge clk);
    #1;
    chk("idle_wb_error_clr", 2, 32'(bus.error_o), 32'd0);

    // Reset during WAIT, then the unit's late writeback lands in IDLE.
    @(negedge clk);
    bus.issue_valid_i      = 1'b1;
    bus.issue_rd_idx_i     = 5'd6;
    bus.issue_ra_operand_i = 32'h0000_0011;
    bus.issue_rb_operand_i = 32'h0000_0022;
    @(negedge clk);
    idle_inputs();
    bus.check_ra_idx_i = 5'd6;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_busy", 3, 32'(bus.busy_o), 32'd1);
    chk("pre_reset_hazard", 3, 32'(bus.hazard_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.writeback_valid_i  = 1'b1;
    bus.writeback_rd_idx_i = 5'd6;
    bus.writeback_value_i  = 32'h0000_0242;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("late_wb_error", 7, 32'(bus.error_o), 32'd1);
    chk("late_wb_rfvalid", 7, 32'(bus.rf_wr_valid_o), 32'd0);
    chk("late_wb_accept", 7, 32'(bus.issue_accept_o), 32'd1);
    @(negedge clk);
    #1;
    chk("late_wb_error_clr", 8, 32'(bus.error_o), 32'd0);
    chk("late_wb_rfvalid2", 8, 32'(bus.rf_wr_valid_o), 32'd0);

    // Controller must still work normally afterwards.
    run_txn(vec[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/biriscv_mul_issue_ctrl.md
# biriscv_mul_issue_ctrl

Issue-side initiator for the multi-cycle multiplier execution unit. Accepts one MUL-class instruction at a time from the issue stage and drives it onto the unit's opcode port. Tracks the pending destination register for hazard checks, captures the unit's writeback and holds it until the register-file write port accepts it. A watchdog and protocol checks report a lost, spurious or mismatched writeback.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8: maximum cycles spent in WAIT before the unit is declared lost (valid range 1..255).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  instruction offered by issue stage.
- issue_accept_o  out  1  controller can take it (state == IDLE).
- issue_opcode_i, issue_pc_i  in  32 each  instruction word, PC.
- issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i  in  5 each  register indices.
- issue_ra_operand_i, issue_rb_operand_i  in  32 each  source operands.
- opcode_valid_o  out  1  one-cycle request to the multiplier.
- opcode_opcode_o, opcode_pc_o  out  32 each  latched instruction, PC.
- opcode_invalid_o  out  1  tied 0.
- opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o  out  5 each  latched indices.
- opcode_ra_operand_o, opcode_rb_operand_o  out  32 each  latched operands.
- writeback_valid_i  in  1  one-cycle completion pulse from the unit.
- writeback_value_i  in  32  result.
- writeback_rd_idx_i  in  5  echoed rd.
- check_ra_idx_i, check_rb_idx_i  in  5 each  source indices of the instruction currently in issue.
- hazard_o  out  1  source matches the pending rd.
- busy_o  out  1  state != IDLE.
- rf_wr_valid_o  out  1  result ready for the register file.
- rf_wr_idx_o  out  5  destination.
- rf_wr_value_o  out  32  result.
- rf_wr_ready_i  in  1  register-file port accepts this cycle.
- error_o  out  1  one-cycle pulse on a protocol fault.

## Operation
- States: IDLE, ISSUE, WAIT, RETIRE.
- IDLE:
  - issue_accept_o = 1.
  - On issue_valid_i, latch all issue_* fields into the opcode_* registers and go to ISSUE.
- ISSUE:
  - opcode_valid_o = 1 for exactly this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On writeback_valid_i with writeback_rd_idx_i == latched rd:
    - rd != 0: capture value into the result register, go to RETIRE.
    - rd == 0: discard the value, go to IDLE; no rf write occurs.
  - On writeback_valid_i with rd mismatch: pulse error_o, discard, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES with no writeback: pulse error_o, go to IDLE.
- RETIRE:
  - rf_wr_valid_o = 1, with rf_wr_idx_o and rf_wr_value_o held stable.
  - Go to IDLE in the cycle rf_wr_ready_i = 1.
  - There is no timeout in RETIRE.
- writeback_valid_i in IDLE, ISSUE or RETIRE is spurious: pulse error_o, ignore the data, keep the state.
- hazard_o = busy_o && rd != 0 && (check_ra_idx_i == rd || check_rb_idx_i == rd). It stays high through RETIRE because there is no forwarding.
- The controller never modifies data; results pass through unchanged.

## Timing
- Reset values:
  - State IDLE.
  - issue_accept_o = 1; busy_o = hazard_o = 0.
  - opcode_valid_o = rf_wr_valid_o = error_o = 0.
  - All data, index and counter registers are 0.
- Reset asserted mid-operation clears everything immediately. A later writeback from the still-running unit lands in IDLE and is flagged as spurious.
- Nominal flow, with the 5-cycle unit and issue accepted at cycle 0:
  - opcode_valid_o at cycle 1.
  - writeback_valid_i at cycle 6.
  - rf_wr_valid_o from cycle 7.
  - With rf_wr_ready_i = 1: IDLE and issue_accept_o = 1 at cycle 8.
  - Back-to-back issue interval is 8 cycles.
- A timeout error_o pulse occurs in the cycle after the counter reaches TIMEOUT_CYCLES; issue_accept_o is high in the same cycle.
- Writeback and timeout in the same cycle: the writeback wins.
- issue_valid_i while not IDLE is not accepted. The issue stage holds its fields; no state is changed.

## Test plan
- Single MUL, rd = 5, ra = 0x00010003, rb = 0x00020005, rf_wr_ready_i = 1 -> opcode_valid_o at cycle 1 only; rf_wr_valid_o at cycle 7 with idx 5, value 0x000B000F; issue_accept_o = 1 at cycle 8.
- Same as above, with rf_wr_ready_i low for 4 cycles -> rf_wr_valid_o, idx and value stable for 5 cycles; hazard_o = 1 for check_ra_idx_i = 5 throughout; hazard_o drops on the accept edge.
- rd = 0 -> writeback consumed; no rf_wr_valid_o; hazard_o never asserts; back to IDLE at cycle 7.
- Unit model never responds, TIMEOUT_CYCLES = 8 -> one error_o pulse 8 cycles after entering WAIT; busy_o falls; next issue is accepted.
- Writeback rd = 7 while pending rd = 9 -> error_o pulse, no rf write; also a writeback pulse in IDLE -> error_o pulse, state unchanged.
- rst_ni pulsed low during WAIT -> all outputs return to reset values asynchronously; the unit's late writeback gives one error_o pulse and no rf write.
